// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - size encodings, FSM states and lane constants for the store narrowing path
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;

  localparam int BE_W = 4;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - shifts a masked store value and its byte mask across two word lanes
module store_lane_align
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]          size,
  input  logic [1:0]          offset,
  input  logic [DATA_W-1:0]   data,
  output logic [2*BE_W-1:0]   be8,
  output logic [2*DATA_W-1:0] d64,
  output logic                split,
  output logic                illegal
);

  logic [BE_W-1:0]   mask;
  logic [DATA_W-1:0] masked;

  always_comb begin
    mask = 4'b0000;
    case (size)
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
  end

  // Only the low bytes of rt belong to the store; upper bytes must not leak into other lanes.
  assign masked  = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign be8     = {4'b0000, mask} << offset;
  assign d64     = {{DATA_W{1'b0}}, masked} << {offset, 3'b000};
  assign split   = |be8[2*BE_W-1:BE_W];
  assign illegal = (size == SZ_ILL);

endmodule

// File: rtl/store_narrow_unit.sv
// rtl/store_narrow_unit.sv - MEM-stage store unit: narrows, aligns and splits stores into word beats
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  output logic              stall,
  output logic              done,
  output logic              err_size
);

  logic [1:0]          state;
  logic [2*BE_W-1:0]   be8;
  logic [2*DATA_W-1:0] d64;
  logic                split;
  logic                illegal;
  logic [ADDR_W-1:0]   base;
  logic                split_q;
  logic [ADDR_W-1:0]   b1_addr;
  logic [DATA_W-1:0]   b1_wdata;
  logic [BE_W-1:0]     b1_be;

  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .size    (req_size),
    .offset  (req_addr[1:0]),
    .data    (req_data),
    .be8     (be8),
    .d64     (d64),
    .split   (split),
    .illegal (illegal)
  );

  assign base      = {req_addr[ADDR_W-1:2], 2'b00};
  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign mem_wr_en = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      split_q   <= 1'b0;
      b1_addr   <= '0;
      b1_wdata  <= '0;
      b1_be     <= '0;
      done      <= 1'b0;
      err_size  <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_size <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              err_size <= 1'b1;
            end else begin
              // Both beats are latched now so later req_* changes cannot disturb the store.
              mem_addr  <= base;
              mem_wdata <= d64[DATA_W-1:0];
              mem_be    <= be8[BE_W-1:0];
              b1_addr   <= base + ADDR_W'(4);
              b1_wdata  <= d64[2*DATA_W-1:DATA_W];
              b1_be     <= be8[2*BE_W-1:BE_W];
              split_q   <= split;
              state     <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (mem_ack) begin
            if (split_q) begin
              mem_addr  <= b1_addr;
              mem_wdata <= b1_wdata;
              mem_be    <= b1_be;
              state     <= BEAT1;
            end else begin
              mem_wdata <= '0;
              mem_be    <= '0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        BEAT1: begin
          if (mem_ack) begin
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb/tb_store_narrow_unit.sv - directed vector bench for store_narrow_unit
module tb_store_narrow_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        stall;
  logic        done;
  logic        err_size;

  int n_cmp;
  int n_fail;

  store_narrow_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .stall     (stall),
    .done      (done),
    .err_size  (err_size)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        split;
    logic [31:0] a0;
    logic [31:0] w0;
    logic [3:0]  be0;
    logic [31:0] a1;
    logic [31:0] w1;
    logic [3:0]  be1;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] w,
                            input logic [3:0] be);
    check({tag, " wr_en"}, 32'(mem_wr_en), 32'd1);
    check({tag, " addr"}, mem_addr, a);
    check({tag, " wdata"}, mem_wdata, w);
    check({tag, " be"}, 32'(mem_be), 32'(be));
    check({tag, " stall"}, 32'(stall), 32'd1);
    check({tag, " ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic accept(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_size  = size;
    req_addr  = addr;
    req_data  = data;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_data  = 32'h5A5A_5A5A;
    req_addr  = 32'hFFFF_FFF0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    accept(v.size, v.addr, v.data);
    mem_ack = 1'b1;
    check_beat({tag, " b0"}, v.a0, v.w0, v.be0);
    check({tag, " b0 done"}, 32'(done), 32'd0);
    @(posedge clock);
    @(negedge clock);
    if (v.split) begin
      check_beat({tag, " b1"}, v.a1, v.w1, v.be1);
      @(posedge clock);
      @(negedge clock);
    end
    mem_ack = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " idle wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, " idle be"}, 32'(mem_be), 32'd0);
    check({tag, " idle wdata"}, mem_wdata, 32'd0);
    check({tag, " ready at done"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    vecs[0] = '{2'b00, 32'h1000_0001, 32'hAABB_CCDD, 1'b0, 32'h1000_0000, 32'h0000_DD00, 4'b0010, 32'h0, 32'h0, 4'b0000};
    vecs[1] = '{2'b10, 32'h1000_0002, 32'h1122_3344, 1'b1, 32'h1000_0000, 32'h3344_0000, 4'b1100, 32'h1000_0004, 32'h0000_1122, 4'b0011};
    vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_BEEF, 1'b1, 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000, 32'h0000_0000, 32'h0000_00BE, 4'b0001};
    vecs[3] = '{2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0000};
    vecs[4] = '{2'b01, 32'h0000_0102, 32'h1234_5678, 1'b0, 32'h0000_0100, 32'h5678_0000, 4'b1100, 32'h0, 32'h0, 4'b0000};
    vecs[5] = '{2'b00, 32'h0000_0203, 32'h0000_00A5, 1'b0, 32'h0000_0200, 32'hA500_0000, 4'b1000, 32'h0, 32'h0, 4'b0000};
    vecs[6] = '{2'b10, 32'h0000_0301, 32'h1122_3344, 1'b1, 32'h0000_0300, 32'h2233_4400, 4'b1110, 32'h0000_0304, 32'h0000_0011, 4'b0001};
    vecs[7] = '{2'b01, 32'h0000_0400, 32'hFFFF_8001, 1'b0, 32'h0000_0400, 32'h0000_8001, 4'b0011, 32'h0, 32'h0, 4'b0000};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    mem_ack   = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst wr_en", 32'(mem_wr_en), 32'd0);
    check("rst addr", mem_addr, 32'd0);
    check("rst wdata", mem_wdata, 32'd0);
    check("rst be", 32'(mem_be), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err_size), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle ack ignored", 32'(mem_wr_en), 32'd0);
    mem_ack = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: ack withheld for 5 beat cycles while req_data churns.
    accept(2'b10, 32'h0000_0020, 32'hCAFE_F00D);
    for (int c = 0; c < 6; c++) begin
      req_data = 32'h0101_0101 * (c + 1);
      check_beat($sformatf("bp c%0d", c), 32'h0000_0020, 32'hCAFE_F00D, 4'b1111);
      check($sformatf("bp c%0d done", c), 32'(done), 32'd0);
      if (c == 5) mem_ack = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    mem_ack = 1'b0;
    check("bp done", 32'(done), 32'd1);
    check("bp idle", 32'(mem_wr_en), 32'd0);
    @(negedge clock);

    // Illegal size.
    accept(2'b11, 32'h0000_0040, 32'h1234_5678);
    check("ill err", 32'(err_size), 32'd1);
    check("ill wr_en", 32'(mem_wr_en), 32'd0);
    check("ill ready", 32'(req_ready), 32'd1);
    check("ill stall", 32'(stall), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check("ill err pulse", 32'(err_size), 32'd0);
    check("ill wr_en2", 32'(mem_wr_en), 32'd0);

    // Reset during BEAT1 of the split word store.
    accept(2'b10, 32'h1000_0002, 32'h1122_3344);
    mem_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_ack = 1'b0;
    check_beat("mr b1", 32'h1000_0004, 32'h0000_1122, 4'b0011);
    reset_n = 1'b0;
    #1;
    check("mr wr_en", 32'(mem_wr_en), 32'd0);
    check("mr addr", mem_addr, 32'd0);
    check("mr wdata", mem_wdata, 32'd0);
    check("mr be", 32'(mem_be), 32'd0);
    check("mr stall", 32'(stall), 32'd0);
    check("mr ready", 32'(req_ready), 32'd1);
    check("mr done", 32'(done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mr no done", 32'(done), 32'd0);
    mem_ack = 1'b0;
    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
MEM-stage store path for the MIPS pipeline. It takes a 32-bit register value and a byte address, then narrows and aligns the value onto the 32-bit data-memory write port with byte enables. This is the opposite direction of the immediate and load sign-extension path: wide to narrow instead of narrow to wide. Misaligned halfword and word stores are split into two word-aligned memory beats, and the block stalls the pipeline while it runs.

Parameters:
- ADDR_W, 32, width of the byte address and memory address.
- DATA_W, 32, data width. Fixed at 32; byte-enable width is DATA_W/8 = 4.

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, store request from EX/MEM.
- req_ready, output, 1, block can accept a request.
- req_size, input, 2, 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_addr, input, ADDR_W, byte address.
- req_data, input, DATA_W, register value (rt); the low bits are significant.
- mem_wr_en, output, 1, write beat valid.
- mem_addr, output, ADDR_W, word-aligned address (bits [1:0] = 00).
- mem_wdata, output, DATA_W, lane-aligned write data.
- mem_be, output, 4, byte enables; bit k enables byte lane k (little-endian lanes).
- mem_ack, input, 1, memory accepted the current beat this cycle.
- stall, output, 1, hold IF/ID/EX while the unit is busy.
- done, output, 1, one-cycle pulse when the store completes.
- err_size, output, 1, one-cycle pulse on an illegal size.

Behaviour:
- Reset is asynchronous, active-low. All state and registered outputs clear and the FSM goes to IDLE:
  - req_ready = 1
  - mem_wr_en = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0
  - stall = 0, done = 0, err_size = 0
- FSM states: IDLE, BEAT0, BEAT1.
- req_ready = (state == IDLE). stall = (state != IDLE).
- Accept happens on a cycle with req_valid && req_ready.
  - k = req_addr[1:0]; base = {req_addr[ADDR_W-1:2], 2'b00}.
  - Byte mask: size 00 -> 0001, size 01 -> 0011, size 10 -> 1111.
  - Lane computation (8-bit mask, 64-bit data):
    - be8 = {4'b0, mask} << k
    - d64 = {32'b0, masked req_data} << (8*k)
  - Beat 0 = (base, d64[31:0], be8[3:0]).
  - Beat 1 = (base + 4 modulo 2^ADDR_W, d64[63:32], be8[7:4]).
  - split = (be8[7:4] != 0).
  - All beat values are captured in registers at accept. Later changes on req_* have no effect.
- Illegal size (11) on accept:
  - No memory write.
  - err_size pulses high for 1 cycle on the next cycle.
  - FSM stays in IDLE.
- Transitions:
  - IDLE -> BEAT0 on a legal accept. Beat 0 appears on mem_* exactly 1 cycle after the accept edge, with mem_wr_en = 1.
  - BEAT0 with mem_ack:
    - split = 1 -> BEAT1; beat 1 is driven in the next cycle.
    - split = 0 -> IDLE, and done pulses in the next cycle.
  - BEAT1 with mem_ack -> IDLE, and done pulses in the next cycle.
  - BEAT0/BEAT1 without mem_ack: hold all mem_* outputs stable (backpressure, unbounded wait).
- In IDLE, mem_wr_en = 0, and mem_wdata and mem_be are driven to 0.
- Minimum latency from accept to done: aligned store = 2 cycles (ack in first beat cycle); split store = 3 cycles.
- A new request can be accepted in the same cycle done is high, since req_ready is 1 there.
- Address wrap: 0xFFFFFFFC + 4 = 0x00000000. No error is raised.
- If reset is asserted mid-store, the remaining beat is abandoned immediately. No done pulse is produced; memory consistency is the caller's responsibility.
- mem_ack while in IDLE is ignored.

Decomposition:
- Package store_pkg:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL
  - state enum: IDLE, BEAT0, BEAT1
  - BE_W = 4
- One sub-module: store_lane_align.
  - Combinational.
  - Inputs: size, offset, data.
  - Outputs: be8 [7:0], d64 [63:0], split, illegal.
  - Instantiated once at the accept point.

Test Plan:
1. Aligned byte store.
   - Stimulus: size 00, addr 0x10000001, data 0xAABBCCDD, ack immediate.
   - Response: one beat with addr 0x10000000, be 0010, wdata 0x0000DD00; done 2 cycles after accept.
2. Split word store.
   - Stimulus: size 10, addr 0x10000002, data 0x11223344.
   - Response:
     - beat 0: addr 0x10000000, be 1100, wdata 0x33440000
     - beat 1: addr 0x10000004, be 0011, wdata 0x00001122
     - single done pulse.
3. Halfword at offset 3 with wrap.
   - Stimulus: size 01, addr 0xFFFFFFFF, data 0x0000BEEF.
   - Response:
     - beat 0: addr 0xFFFFFFFC, be 1000, wdata 0xEF000000
     - beat 1: addr 0x00000000, be 0001, wdata 0x000000BE
4. Backpressure.
   - Stimulus: aligned word store at 0x20, mem_ack held low for 5 cycles; req_data changed during the wait.
   - Response: mem_* stable for all 6 beat cycles; stall = 1 and req_ready = 0 throughout; done follows ack.
5. Illegal size.
   - Stimulus: size 11.
   - Response: mem_wr_en never high; err_size is a 1-cycle pulse; req_ready stays 1.
6. Reset mid-split.
   - Stimulus: reset_n low during BEAT1 of scenario 2.
   - Response: all outputs go to reset values asynchronously; no done; the next aligned store after release works normally.
